button_event_queue: RTL

Downstream consumer of the button manager's hardware press events. Queues Mode, Trip, DayNight and Setting events with millisecond timestamps, so a slow software poll loop loses none of them. Raises a level interrupt to the CPU while the queue is non-empty. Sits on the AHB-lite bus next to the button manager and is drained by software pop-on-read.

---
 rtl/button_event_queue_pkg.sv | 27 ++
 rtl/button_event_queue_if.sv | 17 +
 rtl/button_event_queue_fifo.sv | 51 +++++
 rtl/button_event_queue.sv | 137 +++++++++++++
 4 files changed

// File: rtl/button_event_queue_pkg.sv
// Shared constants and entry type for the button event queue.
// BUTTON_EVENT_TIMESTAMP_EN adds a 16-bit timestamp to every entry.
package button_event_pkg;
  localparam logic [1:0] REG_STATUS = 2'd0;
  localparam logic [1:0] REG_DATA   = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_TIME   = 2'd3;

  localparam int EVT_DAYNIGHT = 0;
  localparam int EVT_MODE     = 1;
  localparam int EVT_TRIP     = 2;
  localparam int EVT_SETTING  = 3;
  localparam int EVT_W        = 4;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
  typedef struct packed {
    logic [15:0]      ts;
    logic [EVT_W-1:0] evts;
  } entry_t;
`else
  typedef struct packed {
    logic [EVT_W-1:0] evts;
  } entry_t;
`endif
endpackage

// File: rtl/button_event_queue_if.sv
// AHB-lite slave port bundle for the button event queue.
interface button_event_queue_if;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [31:0] HRDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic        HREADYOUT;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;

  modport master (output HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
                  input  HRDATA, HREADYOUT);
  modport slave  (input  HADDR, HWDATA, HWRITE, HREADY, HSEL, HSIZE, HTRANS,
                  output HRDATA, HREADYOUT);
endinterface

// File: rtl/button_event_queue_fifo.sv
// Generic synchronous FIFO; a push into a full FIFO is accepted when a pop
// retires the head in the same cycle. Flush wins over push and pop.
module event_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = logic [3:0]
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     push,
  input  T                         din,
  input  logic                     pop,
  input  logic                     flush,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  T               mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  cnt;
  logic           do_push, do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge HCLK)
    if (do_push && !flush) mem[wptr] <= din;
endmodule

// File: rtl/button_event_queue.sv
// AHB-lite event queue for button-manager press events with pop-on-read DATA.
// Define BUTTON_EVENT_TIMESTAMP_EN to timestamp entries with a prescaled tick.
module button_event_queue
  import button_event_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int TICK_DIV = 33
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  button_event_queue_if.slave  bus,
  input  logic                 Evt_DayNight,
  input  logic                 Evt_Mode,
  input  logic                 Evt_Trip,
  input  logic                 Evt_Setting,
  output logic                 IRQ
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic             acc_vld, acc_wr;
  logic [1:0]       acc_addr;
  logic             rd_phase, ctrl_wr, flush, irq_en, overflow;
  logic [EVT_W-1:0] evts;
  logic             push, pop, full, empty;
  logic [CW-1:0]    count;
  entry_t           din, head;
  logic [31:0]      rdata;
  logic             unused_bus;

  assign unused_bus = ^{bus.HSIZE, bus.HADDR[31:4], bus.HADDR[1:0], bus.HWDATA[31:2]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      acc_vld  <= 1'b0;
      acc_wr   <= 1'b0;
      acc_addr <= REG_STATUS;
    end else begin
      acc_vld  <= bus.HSEL && bus.HREADY && (bus.HTRANS != HTRANS_IDLE);
      acc_wr   <= bus.HWRITE;
      acc_addr <= bus.HADDR[3:2];
    end
  end

  assign rd_phase = acc_vld && !acc_wr;
  assign ctrl_wr  = acc_vld && acc_wr && (acc_addr == REG_CTRL);
  assign flush    = ctrl_wr && bus.HWDATA[1];

  assign evts[EVT_DAYNIGHT] = Evt_DayNight;
  assign evts[EVT_MODE]     = Evt_Mode;
  assign evts[EVT_TRIP]     = Evt_Trip;
  assign evts[EVT_SETTING]  = Evt_Setting;

  assign push = (|evts) && !flush;
  assign pop  = rd_phase && (acc_addr == REG_DATA) && !empty;

`ifdef BUTTON_EVENT_TIMESTAMP_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] presc;
  logic [15:0]   ts;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      presc <= '0;
      ts    <= '0;
    end else if (presc == PW'(TICK_DIV - 1)) begin
      presc <= '0;
      ts    <= ts + 16'd1;
    end else begin
      presc <= presc + 1'b1;
    end
  end
`endif

  always_comb begin
    din      = '0;
    din.evts = evts;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
    din.ts   = ts;
`endif
  end

  event_fifo #(.DEPTH(DEPTH), .T(entry_t)) u_fifo (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .push    (push),
    .din     (din),
    .pop     (pop),
    .flush   (flush),
    .dout    (head),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // A push lost to a full queue is only an overflow if no pop frees a slot.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_en   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= bus.HWDATA[0];
      if (flush)                          overflow <= 1'b0;
      else if (push && full && !pop)      overflow <= 1'b1;
    end
  end

  always_comb begin
    rdata = '0;
    if (rd_phase) begin
      case (acc_addr)
        REG_STATUS: begin
          rdata[4:0] = 5'(count);
          rdata[8]   = overflow;
          rdata[9]   = empty;
        end
        REG_DATA: begin
          if (!empty) begin
            rdata[3:0]   = head.evts;
`ifdef BUTTON_EVENT_TIMESTAMP_EN
            rdata[31:16] = head.ts;
`endif
          end
        end
        REG_CTRL: rdata[0] = irq_en;
        default: begin
`ifdef BUTTON_EVENT_TIMESTAMP_EN
          rdata[15:0] = ts;
`endif
        end
      endcase
    end
  end

  assign bus.HRDATA    = rdata;
  assign bus.HREADYOUT = 1'b1;
  assign IRQ           = irq_en && !empty;
endmodule
